// File: rtl/bram_lut_mult2.sv
// Two-lane lookup-table multiplier: the product table is built into a dual-port RAM
// after reset (or on init_start), then each RAM port serves one valid/ready lane.
module bram_lut_mult2 #(
    parameter int DATA_WIDTH = 4,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_start,
    output logic                      init_done,
    input  logic                      in_valid0,
    output logic                      in_ready0,
    input  logic [DATA_WIDTH-1:0]     opA0,
    input  logic [DATA_WIDTH-1:0]     opB0,
    output logic                      out_valid0,
    output logic [2*DATA_WIDTH-1:0]   out_data0,
    input  logic                      in_valid1,
    output logic                      in_ready1,
    input  logic [DATA_WIDTH-1:0]     opA1,
    input  logic [DATA_WIDTH-1:0]     opB1,
    output logic                      out_valid1,
    output logic [2*DATA_WIDTH-1:0]   out_data1
);
    localparam int W     = DATA_WIDTH;
    localparam int AW    = 2 * DATA_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-2:0] CNT_ONE = {{(AW-2){1'b0}}, 1'b1};
    localparam logic [AW-2:0] CNT_MAX = {(AW-1){1'b1}};
    localparam logic [AW-2:0] CNT_ZERO = {(AW-1){1'b0}};

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Table entry for an address {a, b}: a*b, sign-extended first in signed mode.
    function automatic logic [AW-1:0] lut_product(input logic [AW-1:0] addr);
        logic [AW-1:0] a_ext;
        logic [AW-1:0] b_ext;
        if (SIGNED) begin
            a_ext = {{W{addr[AW-1]}}, addr[AW-1:W]};
            b_ext = {{W{addr[W-1]}}, addr[W-1:0]};
        end else begin
            a_ext = {{W{1'b0}}, addr[AW-1:W]};
            b_ext = {{W{1'b0}}, addr[W-1:0]};
        end
        return a_ext * b_ext;
    endfunction

    state_t          state_q, state_d;
    logic [AW-2:0]   cnt_q, cnt_d;
    logic            done_q;
    logic            fill_s;
    logic            accept0_s, accept1_s;
    logic [AW-1:0]   addr0_s, addr1_s;
    logic [AW-1:0]   wdata0_s, wdata1_s;
    logic [AW-1:0]   ram_q [DEPTH];
    logic [AW-1:0]   rd0_q, rd1_q;
    logic            acc0_q, acc1_q;
    logic            out_valid0_q, out_valid1_q;
    logic [AW-1:0]   out_data0_q, out_data1_q;

    assign fill_s    = (state_q == ST_FILL);
    assign accept0_s = in_valid0 & done_q;
    assign accept1_s = in_valid1 & done_q;
    // Port 0 fills the lower half of the table, port 1 the upper half.
    assign addr0_s   = fill_s ? {1'b0, cnt_q} : {opA0, opB0};
    assign addr1_s   = fill_s ? {1'b1, cnt_q} : {opA1, opB1};
    assign wdata0_s  = lut_product(addr0_s);
    assign wdata1_s  = lut_product(addr1_s);

    // Next-state and fill counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_FILL: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_READY: begin
                if (init_start) begin
                    state_d = ST_FILL;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_FILL;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and ready flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= CNT_ZERO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == ST_READY);
        end
    end

    // Dual-port table RAM: fill writes on both ports, synchronous reads per lane.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            ram_q[addr0_s] <= wdata0_s;
            ram_q[addr1_s] <= wdata1_s;
        end
        rd0_q <= ram_q[addr0_s];
        rd1_q <= ram_q[addr1_s];
    end

    // Result pipeline: accept flag follows the RAM read, output register one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0_q       <= 1'b0;
            acc1_q       <= 1'b0;
            out_valid0_q <= 1'b0;
            out_valid1_q <= 1'b0;
            out_data0_q  <= {AW{1'b0}};
            out_data1_q  <= {AW{1'b0}};
        end else begin
            acc0_q       <= accept0_s;
            acc1_q       <= accept1_s;
            out_valid0_q <= acc0_q;
            out_valid1_q <= acc1_q;
            if (acc0_q) begin
                out_data0_q <= rd0_q;
            end
            if (acc1_q) begin
                out_data1_q <= rd1_q;
            end
        end
    end

    assign init_done  = done_q;
    assign in_ready0  = done_q;
    assign in_ready1  = done_q;
    assign out_valid0 = out_valid0_q;
    assign out_valid1 = out_valid1_q;
    assign out_data0  = out_data0_q;
    assign out_data1  = out_data1_q;

endmodule

// File: tb/tb_bram_lut_mult2.sv
// Scoreboard bench for bram_lut_mult2: an unsigned and a signed instance (W=4),
// expected products from an integer reference model, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_bram_lut_mult2;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_start [2];
    logic       init_done  [2];
    logic       in_valid   [4];
    logic       in_ready   [4];
    logic [3:0] opa        [4];
    logic [3:0] opb        [4];
    logic       out_valid  [4];
    logic [7:0] out_data   [4];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_lut_mult2 #(.DATA_WIDTH(4), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .init_start(init_start[0]), .init_done(init_done[0]),
        .in_valid0(in_valid[0]), .in_ready0(in_ready[0]), .opA0(opa[0]), .opB0(opb[0]),
        .out_valid0(out_valid[0]), .out_data0(out_data[0]),
        .in_valid1(in_valid[1]), .in_ready1(in_ready[1]), .opA1(opa[1]), .opB1(opb[1]),
        .out_valid1(out_valid[1]), .out_data1(out_data[1])
    );

    bram_lut_mult2 #(.DATA_WIDTH(4), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .init_start(init_start[1]), .init_done(init_done[1]),
        .in_valid0(in_valid[2]), .in_ready0(in_ready[2]), .opA0(opa[2]), .opB0(opb[2]),
        .out_valid0(out_valid[2]), .out_data0(out_data[2]),
        .in_valid1(in_valid[3]), .in_ready1(in_ready[3]), .opA1(opa[3]), .opB1(opb[3]),
        .out_valid1(out_valid[3]), .out_data1(out_data[3])
    );

    // Reference product: plain integer multiply, operands reinterpreted as signed if needed.
    function automatic logic [7:0] ref_mul(input bit sgn, input int a, input int b);
        int x;
        int y;
        int p;
        x = a;
        y = b;
        if (sgn) begin
            if (x > 7) x = x - 16;
            if (y > 7) y = y - 16;
        end
        p = x * y;
        return p[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input exp_t e);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic mon(input int id);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (out_valid[id] === 1'b1) begin
            case (id)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid lane%0d: out_valid=1 required 0 (data %0h, cycle %0d)",
                         id, out_data[id], cyc);
            end else begin
                chk($sformatf("latency lane%0d", id), cyc, e.cyc);
                chk($sformatf("data lane%0d", id), {24'd0, out_data[id]}, {24'd0, e.d});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 4; i++) mon(i);
        end
    end

    task automatic req(input int id, input int a, input int b);
        in_valid[id] = 1'b1;
        opa[id]      = a[3:0];
        opb[id]      = b[3:0];
    endtask

    // One clock: record accepted requests in the scoreboard, advance, clear strobes.
    task automatic step();
        exp_t e;
        for (int id = 0; id < 4; id++) begin
            if (in_valid[id] === 1'b1 && in_ready[id] === 1'b1) begin
                e.cyc = cyc + 2;
                e.d   = ref_mul(id >= 2, int'(opa[id]), int'(opb[id]));
                push(id, e);
            end
        end
        @(posedge clk);
        #1;
        for (int id = 0; id < 4; id++) in_valid[id] = 1'b0;
        init_start[0] = 1'b0;
        init_start[1] = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        for (int id = 0; id < 4; id++) begin
            chk({name, " out_valid"}, {31'd0, out_valid[id]}, 32'd0);
            chk({name, " out_data"},  {24'd0, out_data[id]}, 32'd0);
            chk({name, " in_ready"},  {31'd0, in_ready[id]}, 32'd0);
        end
        chk({name, " init_done0"}, {31'd0, init_done[0]}, 32'd0);
        chk({name, " init_done1"}, {31'd0, init_done[1]}, 32'd0);
    endtask

    // Count edges until init_done of one instance; optionally hammer it with requests.
    task automatic count_fill(input string name, input int dut, input bit junk, input bit zeros);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 400) begin
            if (junk) begin
                req(dut * 2, $urandom_range(15), $urandom_range(15));
                req(dut * 2 + 1, $urandom_range(15), $urandom_range(15));
                if (n == 40) init_start[dut] = 1'b1;
            end
            step();
            n++;
            if (init_done[dut] === 1'b1) begin
                done = 1'b1;
            end else begin
                chk({name, " in_ready0 low"}, {31'd0, in_ready[dut * 2]}, 32'd0);
                chk({name, " in_ready1 low"}, {31'd0, in_ready[dut * 2 + 1]}, 32'd0);
                if (zeros) begin
                    chk({name, " out_valid0 low"}, {31'd0, out_valid[dut * 2]}, 32'd0);
                    chk({name, " out_data0 zero"}, {24'd0, out_data[dut * 2]}, 32'd0);
                end
            end
        end
        chk({name, " edges"}, n, 32'd128);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        init_start[0] = 1'b0;
        init_start[1] = 1'b0;
        for (int id = 0; id < 4; id++) begin
            in_valid[id] = 1'b0;
            opa[id] = 4'd0;
            opb[id] = 4'd0;
        end
        #1 rst_n = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        count_fill("fill_after_reset", 0, 1'b0, 1'b1);
        chk("signed init_done", {31'd0, init_done[1]}, 32'd1);

        // directed products, unsigned then signed corners
        req(0, 15, 15); req(1, 7, 3);
        req(2, 8, 8);   req(3, 8, 7);
        step();
        req(2, 15, 15); req(3, 0, 11);
        step();
        repeat (3) step();

        // exhaustive back-to-back, lane 1 in reverse order
        for (int i = 0; i < 256; i++) begin
            req(0, i >> 4, i & 15);
            req(1, (255 - i) >> 4, (255 - i) & 15);
            req(2, i >> 4, i & 15);
            req(3, (255 - i) >> 4, (255 - i) & 15);
            step();
        end
        repeat (3) step();

        // random traffic with random gaps
        for (int i = 0; i < 300; i++) begin
            for (int id = 0; id < 4; id++) begin
                if ($urandom_range(1) == 1) req(id, $urandom_range(15), $urandom_range(15));
            end
            step();
        end
        repeat (3) step();

        // init_start together with an accept; requests and a second init_start during fill
        req(0, 3, 5);
        init_start[0] = 1'b1;
        step();
        count_fill("fill_after_init", 0, 1'b1, 1'b0);
        repeat (3) step();

        // reset pulse in the middle of a fill
        init_start[0] = 1'b1;
        step();
        repeat (60) step();
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        count_fill("fill_after_midfill_reset", 0, 1'b0, 1'b1);
        req(0, 2, 3);
        step();
        repeat (3) step();

        chk("leftover lane0", q0.size(), 32'd0);
        chk("leftover lane1", q1.size(), 32'd0);
        chk("leftover lane2", q2.size(), 32'd0);
        chk("leftover lane3", q3.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_lut_mult2.md
# bram_lut_mult2

Two-lane BRAM lookup-table multiplier with parametrised operand width and signed or unsigned mode. After reset it builds its own product table using both RAM ports, then serves two independent valid/ready multiply streams, one per RAM port, at full throughput. It replaces the fixed 4-bit BRAM/DSP multiplier top-level and needs no external table preload and no magic start code.

## Interface
Parameters:
- DATA_WIDTH, 4, operand width W; table depth is 2^(2W) entries, entry width 2W. Legal range is 2..8.
- SIGNED, 0. 0 means operands and products are unsigned. 1 means they are two's complement.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_start  in  1  single-cycle request to rebuild the table. Honoured only in READY.
- init_done  out  1  high in READY.
- in_valid0 / in_valid1  in  1  operand pair valid, lane 0 / lane 1.
- in_ready0 / in_ready1  out  1  lane can accept. Equals init_done.
- opA0, opB0 / opA1, opB1  in  W each  operands, lane 0 / lane 1.
- out_valid0 / out_valid1  out  1  one-cycle result strobe.
- out_data0 / out_data1  out  2W  product opA*opB.

## Operation
- Internal true dual-port RAM: 2^(2W) x 2W, synchronous read, inferable as block RAM. Address is {opA, opB}, with opA in the MSBs.
- FSM states:
  - FILL: both ports write. Counter cnt runs 0..2^(2W-1)-1. Port 0 writes address cnt. Port 1 writes address cnt + 2^(2W-1). Data at each address is the product of its upper W bits and lower W bits.
    - The product is computed combinationally from the address, in signed or unsigned form per SIGNED.
    - Write enables are active only in FILL.
    - When cnt reaches its maximum, the last write occurs and the FSM moves to READY.
  - READY: in_ready0 and in_ready1 are 1. Port k serves lane k only. There is no arbitration; both lanes may read the same address in the same cycle.
    - If init_start is sampled high, the FSM clears cnt and moves to FILL.
- Entry to FILL: reset deassertion starts FILL automatically. The table content is undefined until the first FILL completes.
- init_start is ignored in FILL. It does not extend or restart the fill.
- Requests are not accepted in FILL (in_ready = 0). Their out_valid never fires.
- Simultaneous accept and init_start in READY: the accept is taken, because in_ready is still 1 that cycle. The read occurs at the same edge, before any FILL write. The result is delivered normally.
- In-flight results are always delivered, even if the FSM has moved to FILL.
- There is no output backpressure. The consumer must sink one result per lane per cycle.
- Arithmetic:
  - Unsigned: product = opA*opB, which fits in 2W bits.
  - Signed: product is the 2W-bit two's complement. (-2^(W-1))^2 = 2^(2W-2) fits.

## Timing
- Reset (rst_n low, asynchronous) clears the following immediately:
  - init_done, in_ready0/1, out_valid0/1 go to 0.
  - out_data0/1 go to 0.
  - cnt goes to 0 and the state goes to FILL.
- Reset asserted mid-fill or mid-stream discards all state. Fill restarts from cnt = 0 with full duration.
- Fill duration: the first write occurs at the first rising edge with rst_n high. Writes occur on 2^(2W-1) consecutive edges, which is 128 for W=4. init_done is high in the cycle following the last write edge.
- Lookup latency is 2:
  - Accept at edge k (in_valid & in_ready).
  - RAM read at edge k.
  - Output register loads at edge k+1.
  - out_valid is high for the one cycle after edge k+1, with out_data valid that cycle.
- Throughput: one result per lane per cycle. out_valid is continuous under back-to-back accepts.
- Between results out_valid is 0. out_data holds its last value.

## Test plan
- Reset release with W=4: count edges to init_done → init_done rises after exactly 128 write edges. All outputs are 0 during reset and during FILL.
- Unsigned, same cycle: lane 0 15×15 and lane 1 7×3 → two cycles later out_data0 = 0xE1 (225) and out_data1 = 0x15 (21), both out_valid high for one cycle.
- SIGNED=1, W=4: -8×-8 → 0x40. -8×7 → 0xC8. -1×-1 → 0x01. 0×-5 → 0x00.
- Exhaustive stream: 256 back-to-back pairs on both lanes, with lane 1 in reverse order → every result matches the reference model, out_valid stays unbroken for 256 cycles, no gaps.
- init_start in the same cycle as a lane-0 accept of 3×5 → out_data0 = 0x0F is delivered. in_ready stays low for 128 cycles. Requests driven during FILL produce no out_valid. A second init_start mid-FILL does not lengthen the fill.
- rst_n pulsed low at fill edge 60 → outputs are 0 asynchronously. After release, init_done rises after a full 128 edges. A 2×3 lookup then returns 0x06.
